// File: rtl/nn_pkg.sv
// Shared types and constants for the skin-classifier feature sequencer.
package nn_pkg;

  localparam int unsigned SAMPLE_W = 17;
  localparam int unsigned N_FEAT   = 7;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CNT_W    = 8;

  // 1.0 in s4i12f
  localparam logic signed [SAMPLE_W-1:0] NN_ONE = 17'sd4096;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    RESULT  = 2'd2
  } state_t;

endpackage

// File: rtl/nn_feat_buffer.sv
// Shadow register file for one feature vector with a parallel-load output stage.
module nn_feat_buffer
  import nn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        sop,
  input  logic [16:0] data,
  output logic        last_c,
  output logic        resync_c,
  output logic [16:0] x1,
  output logic [16:0] x2,
  output logic [16:0] x3,
  output logic [16:0] x4,
  output logic [16:0] x5,
  output logic [16:0] x6,
  output logic [16:0] x7
);

  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] slot_c;
  sample_t          shadow [N_FEAT];

  // A start-of-vector sample always lands in slot 0
  assign slot_c   = sop ? '0 : index;
  assign last_c   = wr && !sop && (index == IDX_W'(N_FEAT - 1));
  assign resync_c = wr && sop && (index != '0);

  // Shadow write, index advance and simultaneous load of all seven outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      for (int i = 0; i < int'(N_FEAT); i++) shadow[i] <= '0;
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
      x5 <= '0;
      x6 <= '0;
      x7 <= '0;
    end else if (wr) begin
      shadow[slot_c] <= sample_t'(data);
      index          <= last_c ? '0 : IDX_W'(slot_c + 1'b1);
      if (last_c) begin
        // Slot 6 is being written this edge, so x7 takes the incoming sample
        x1 <= shadow[0];
        x2 <= shadow[1];
        x3 <= shadow[2];
        x4 <= shadow[3];
        x5 <= shadow[4];
        x6 <= shadow[5];
        x7 <= data;
      end
    end
  end

endmodule

// File: rtl/nn_feature_sequencer.sv
// Serial-to-parallel feature sequencer, network ce window and result capture.
module nn_feature_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned        NN_LATENCY = 4,
  parameter logic signed [16:0] THRESH     = 17'sd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] s_data,
  input  logic        s_sop,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [16:0] x1,
  output logic [16:0] x2,
  output logic [16:0] x3,
  output logic [16:0] x4,
  output logic [16:0] x5,
  output logic [16:0] x6,
  output logic [16:0] x7,
  output logic        nn_ce,
  input  logic [16:0] nn_y,
  output logic [16:0] m_y,
  output logic        m_class,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  resync_cnt
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] lat_cnt_nx;
  logic             s_ready_nx;
  logic             nn_ce_nx;
  logic             m_valid_nx;
  logic             capture_nx;
  logic             hs_c;
  logic             last_c;
  logic             resync_c;

  assign hs_c = s_valid && s_ready;

  nn_feat_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr       (hs_c),
    .sop      (s_sop),
    .data     (s_data),
    .last_c   (last_c),
    .resync_c (resync_c),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .x4       (x4),
    .x5       (x5),
    .x6       (x6),
    .x7       (x7)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  // Next state and next values of the registered handshake/ce decodes
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = '0;
    capture_nx = 1'b0;
    case (state)
      COLLECT: if (last_c) state_nx = COMPUTE;
      COMPUTE: begin
        if (lat_cnt == CNT_W'(NN_LATENCY - 1)) begin
          state_nx   = RESULT;
          capture_nx = 1'b1;
        end else begin
          lat_cnt_nx = CNT_W'(lat_cnt + 1'b1);
        end
      end
      RESULT:  if (m_valid && m_ready) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
    s_ready_nx = (state_nx == COLLECT);
    nn_ce_nx   = (state_nx == COMPUTE);
    m_valid_nx = (state_nx == RESULT);
  end

  // Registered handshake outputs, latency counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b1;
      nn_ce   <= 1'b0;
      m_valid <= 1'b0;
      lat_cnt <= '0;
      m_y     <= '0;
      m_class <= 1'b0;
    end else begin
      s_ready <= s_ready_nx;
      nn_ce   <= nn_ce_nx;
      m_valid <= m_valid_nx;
      lat_cnt <= lat_cnt_nx;
      if (capture_nx) begin
        m_y     <= nn_y;
        m_class <= ($signed(nn_y) >= $signed(THRESH));
      end
    end
  end

  // Saturating count of vectors abandoned by a mid-vector start marker
  always_ff @(posedge clk) begin
    if (rst)                                resync_cnt <= '0;
    else if (resync_c && resync_cnt != '1) resync_cnt <= CNT_W'(resync_cnt + 1'b1);
  end

endmodule

// File: tb/tb_nn_feature_sequencer.sv
// Scoreboard bench for nn_feature_sequencer with a vector-level reference model.
module tb_nn_feature_sequencer;

  localparam int LAT = 4;
  localparam int TH  = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] s_data;
  logic        s_sop;
  logic        s_valid;
  logic        s_ready;
  logic [16:0] x1, x2, x3, x4, x5, x6, x7;
  logic        nn_ce;
  logic [16:0] nn_y;
  logic [16:0] m_y;
  logic        m_class;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  resync_cnt;

  nn_feature_sequencer #(.NN_LATENCY(LAT), .THRESH(17'sd2048)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sop(s_sop), .s_valid(s_valid),
    .s_ready(s_ready), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
    .x7(x7), .nn_ce(nn_ce), .nn_y(nn_y), .m_y(m_y), .m_class(m_class),
    .m_valid(m_valid), .m_ready(m_ready), .resync_cnt(resync_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [16:0] x [7];
    logic [16:0] y;
    int          done;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [16:0] mbuf [7];
  int          mcnt = 0;
  int          mres = 0;
  logic [16:0] y_next = 17'd3000;
  int          rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled
  bit          chk_spacing = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a vector is seven accepted samples; a start marker restarts it
  task automatic model_accept(input logic [16:0] d, input bit sop, input int c);
    exp_t e;
    if (sop) begin
      if (mcnt != 0 && mres < 255) mres++;
      mbuf[0] = d;
      mcnt = 1;
    end else begin
      mbuf[mcnt] = d;
      mcnt++;
    end
    if (mcnt == 7) begin
      for (int i = 0; i < 7; i++) e.x[i] = mbuf[i];
      e.y    = y_next;
      e.done = c;
      exp_q.push_back(e);
      nn_y = y_next;
      mcnt = 0;
    end
  endtask

  // Offer one sample and hold it until accepted; starts and ends just after a rising edge
  task automatic send(input logic [16:0] d, input bit sop);
    bit hs = 1'b0;
    int c = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    for (int k = 0; k < 300 && !hs; k++) begin
      @(negedge clk);
      hs = s_ready;
      c  = cyc;
      @(posedge clk);
      #1;
    end
    if (!hs) check("accept_timeout", 0, 1);
    else     model_accept(d, sop, c);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sop   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [16:0] v [7], input bit first_sop);
    for (int i = 0; i < 7; i++) send(v[i], (i == 0) && first_sop);
  endtask

  task automatic rand_vec(output logic [16:0] v [7]);
    for (int i = 0; i < 7; i++) v[i] = 17'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // Result consumer
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard whenever a result is presented
  int ce_cnt = 0;
  bit in_res = 1'b0;
  bit expect_low = 1'b0;
  int prev_rise = -1;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      ce_cnt = 0;
      in_res = 1'b0;
      expect_low = 1'b0;
    end else begin
      if (expect_low) begin
        check("m_valid_one_cycle", m_valid, 0);
        expect_low = 1'b0;
      end
      if (nn_ce) ce_cnt++;
      if (m_valid) begin
        check("s_ready_in_result", s_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          exp_t e;
          logic [16:0] xo [7];
          e = exp_q[0];
          if (!in_res) begin
            in_res = 1'b1;
            xo[0] = x1; xo[1] = x2; xo[2] = x3; xo[3] = x4;
            xo[4] = x5; xo[5] = x6; xo[6] = x7;
            check("result_latency", cyc, e.done + LAT + 1);
            check("nn_ce_cycles", ce_cnt, LAT);
            for (int i = 0; i < 7; i++) check($sformatf("x%0d", i + 1), xo[i], e.x[i]);
            if (chk_spacing && prev_rise >= 0) check("result_spacing", cyc - prev_rise, 12);
            prev_rise = chk_spacing ? cyc : -1;
          end
          check("m_y", m_y, e.y);
          check("m_class", m_class, int'($signed(e.y) >= TH));
          if (m_ready) begin
            void'(exp_q.pop_front());
            in_res = 1'b0;
            ce_cnt = 0;
            expect_low = 1'b1;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [16:0] vec [7];
    logic [16:0] rv [7];
    bit ok;
    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_data = '0; nn_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_nn_ce", nn_ce, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_x1", x1, 0);
    check("rst_x7", x7, 0);
    check("rst_m_y", m_y, 0);
    check("rst_resync", resync_cnt, 0);
    rst = 1'b0;

    // Directed vector against threshold neighbours and a negative result
    vec[0] = 17'(4096); vec[1] = 17'(0); vec[2] = 17'(-4096); vec[3] = 17'(2048);
    vec[4] = 17'(1);    vec[5] = 17'(-1); vec[6] = 17'(8191);
    y_next = 17'(3000);  send_vec(vec, 1'b0);
    y_next = 17'(2047);  send_vec(vec, 1'b0);
    y_next = 17'(2048);  send_vec(vec, 1'b0);
    y_next = 17'(-5);    send_vec(vec, 1'b0);
    drain();

    // Consumer stall with ignored sample pulses
    rdy_mode = 2;
    y_next = 17'(1234);
    send_vec(vec, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin @(negedge clk); ok = m_valid; end
    if (!ok) check("stall_wait_timeout", 0, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 17'($urandom);
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_m_valid", m_valid, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rdy_mode = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clk); ok = m_valid && m_ready; end
    if (!ok) check("release_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    check("s_ready_after_release", s_ready, 1);
    @(posedge clk); #1;

    // Mid-vector start marker
    for (int i = 0; i < 3; i++) send(17'($urandom), 1'b0);
    rand_vec(rv);
    y_next = 17'(-100);
    send_vec(rv, 1'b1);
    drain();
    check("resync_one", resync_cnt, mres);

    // Reset during the second compute cycle
    rand_vec(rv);
    y_next = 17'(500);
    send_vec(rv, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    mres = 0;
    check("rstmid_nn_ce", nn_ce, 0);
    check("rstmid_m_valid", m_valid, 0);
    check("rstmid_x1", x1, 0);
    check("rstmid_x4", x4, 0);
    check("rstmid_x7", x7, 0);
    check("rstmid_s_ready", s_ready, 1);
    rand_vec(rv);
    y_next = 17'(4095);
    send_vec(rv, 1'b0);
    drain();

    // Back-to-back throughput
    chk_spacing = 1'b1;
    for (int v = 0; v < 4; v++) begin
      rand_vec(rv);
      y_next = 17'($urandom);
      send_vec(rv, v[0]);
    end
    drain();
    chk_spacing = 1'b0;

    // Resync counter saturation
    for (int i = 0; i < 301; i++) send(17'($urandom), 1'b1);
    idle(1);
    check("resync_saturate", resync_cnt, mres);
    check("resync_at_255", mres, 255);
    for (int i = 0; i < 6; i++) send(17'($urandom), 1'b0);
    drain();

    // Randomized traffic with random consumer backpressure
    rdy_mode = 1;
    for (int v = 0; v < 40; v++) begin
      bit abort;
      abort = ($urandom_range(0, 7) == 0);
      if (abort) for (int i = 0; i < int'($urandom_range(1, 3)); i++) send(17'($urandom), 1'b0);
      case ($urandom_range(0, 3))
        0:       y_next = 17'(2047);
        1:       y_next = 17'(2048);
        default: y_next = 17'($urandom);
      endcase
      rand_vec(rv);
      for (int i = 0; i < 7; i++) begin
        send(rv[i], (i == 0) && (abort || $urandom_range(0, 1) == 1));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    drain();
    check("resync_final", resync_cnt, mres);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_feature_sequencer.md
Name: nn_feature_sequencer

Overview:
- Front/back end of the skin-classifier neural network.
- Collects the 7 skin parameters from a serial valid/ready sample stream and presents them in parallel to the network's x1..x7 inputs.
- Gates the network's ce for a fixed compute window, then captures y_out and returns it with a skin/non-skin decision on a valid/ready result port.
- All data is 17-bit signed s4i12f (one = 17'sd4096).

Parameters:
- N_FEAT, 7, number of features per vector (fixed by network topology).
- SAMPLE_W, 17, sample and result width (s4i12f).
- NN_LATENCY, 4, cycles nn_ce is held high per vector; must be ≥ network pipeline depth; legal range 1..255.
- THRESH, 17'sd2048, class threshold (0.5 in s4i12f).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_data  in  17  serial feature sample, s4i12f
- s_sop  in  1  marks sample as feature 1 of a vector
- s_valid  in  1  sample valid
- s_ready  out  1  sequencer can accept a sample
- x1..x7  out  17 each  parallel feature vector to network
- nn_ce  out  1  clock enable to network
- nn_y  in  17  network output y_out
- m_y  out  17  captured network result
- m_class  out  1  1 = skin (signed m_y ≥ THRESH)
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- resync_cnt  out  8  saturating count of vectors discarded by s_sop mid-vector

Behaviour:
- Reset (sync, rst=1 at clk edge) values:
  - state=COLLECT, index=0.
  - Shadow buffer, x1..x7, m_y, m_class, nn_ce, m_valid, resync_cnt all 0.
  - Reset mid-operation drops any partial vector, compute window or pending result.
- States: COLLECT, COMPUTE, RESULT.
- COLLECT:
  - s_ready=1, nn_ce=0.
  - A handshake is s_valid & s_ready.
  - Handshake with s_sop=1: sample written to slot 0, index←1. If index≠0 beforehand, resync_cnt increments, saturating at 255.
  - Handshake with s_sop=0: sample written to slot index, index←index+1. s_sop is optional on the first sample.
  - Handshake that fills slot 6: x1..x7 are loaded simultaneously from the shadow buffer (slot0→x1 … slot6→x7) at that edge, index←0, latency counter←0, state→COMPUTE.
  - x outputs change only on this edge. They hold through COMPUTE, RESULT and the next COLLECT.
- COMPUTE:
  - s_ready=0, nn_ce=1 for exactly NN_LATENCY consecutive cycles.
  - On the edge ending the last nn_ce cycle: m_y←nn_y, m_class←($signed(nn_y) ≥ $signed(THRESH)), m_valid←1, nn_ce←0, state→RESULT.
  - Latency: last input handshake at cycle T → nn_ce high T+1..T+NN_LATENCY → m_valid high from T+NN_LATENCY+1.
- RESULT:
  - s_ready=0, nn_ce=0; m_y and m_class held stable while m_valid=1.
  - m_valid & m_ready: m_valid←0 at that edge, state→COLLECT. The next sample is accepted at the earliest in the following cycle.
  - m_ready held high gives a throughput of one vector per 7+NN_LATENCY+1 cycles.
- Comparison is signed. Negative results classify 0. Equality with THRESH classifies 1.
- s_valid while s_ready=0 is ignored, not queued; the upstream must hold data.
- s_ready, nn_ce and m_valid are registered state decodes with no combinational path from inputs.

Decomposition:
- Package nn_pkg:
  - SAMPLE_W=17, N_FEAT=7, NN_ONE=17'sd4096.
  - Typedef sample_t (signed [16:0]).
  - State enum {COLLECT, COMPUTE, RESULT}.
- One sub-module: nn_feat_buffer, a 7×17 shadow register file with write index and a parallel-load output stage.
- FSM, latency counter and result capture stay in the top.

Test Plan:
- Vector 4096,0,−4096,2048,1,−1,8191 with no sop, m_ready=1, stub nn_y=3000 during compute → x1..x7 equal those values, nn_ce high exactly 4 cycles, m_y=3000, m_class=1, m_valid one cycle.
- Same vector with nn_y=2047, then 2048, then −5 → m_class=0, 1, 0.
- m_ready=0 for 10 cycles after m_valid → m_valid, m_y and m_class held; s_ready=0; s_valid pulses ignored. m_ready=1 → s_ready=1 the next cycle.
- 3 samples, then s_sop sample followed by 6 more → resync_cnt=1; x1 equals the sop sample; only one result produced.
- rst asserted during cycle 2 of COMPUTE → next cycle nn_ce=0, m_valid=0, x1..x7=0, s_ready=1. A fresh 7-sample vector then completes normally.
- Back-to-back vectors with s_valid and m_ready held high → result spacing exactly 12 cycles (NN_LATENCY=4). 300 forced resyncs → resync_cnt saturates at 255.
